// File: rtl/alu_operand_sequencer.sv
// alu_operand_sequencer: serial front end for a combinational ALU.
// Gathers opcode / operand A / operand B from one input stream, drives the
// ALU from registers for one execute cycle, then holds the captured result
// (with a divide-by-zero flag) on an output valid/ready handshake.
module alu_operand_sequencer #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [2:0]            alu_oc,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    input  logic [DATA_WIDTH-1:0] alu_f,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_err,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [15:0]           op_count
);

    localparam logic [2:0] OC_DIV = 3'b011;
    localparam logic [2:0] OC_NOT = 3'b100;

    typedef enum logic [2:0] {
        S_OC   = 3'd0,
        S_A    = 3'd1,
        S_B    = 3'd2,
        S_EXEC = 3'd3,
        S_OUT  = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [2:0]            oc_q, oc_d;
    logic [DATA_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  err_q, err_d;
    logic                  valid_q, valid_d;
    logic [15:0]           op_count_q, op_count_d;

    // A divide with a zero divisor has no defined ALU result.
    function automatic logic is_div_by_zero(input logic [2:0] oc,
                                            input logic [DATA_WIDTH-1:0] b);
        return (oc == OC_DIV) && (b == '0);
    endfunction

    // Result word captured at the end of S_EXEC; forced to zero on divide-by-zero.
    function automatic logic [DATA_WIDTH-1:0] select_result(input logic [2:0] oc,
                                                            input logic [DATA_WIDTH-1:0] b,
                                                            input logic [DATA_WIDTH-1:0] f);
        return is_div_by_zero(oc, b) ? '0 : f;
    endfunction

    // State and datapath registers; reset discards any partial operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_OC;
            oc_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            data_q     <= '0;
            err_q      <= 1'b0;
            valid_q    <= 1'b0;
            op_count_q <= '0;
        end else begin
            state_q    <= state_d;
            oc_q       <= oc_d;
            a_q        <= a_d;
            b_q        <= b_d;
            data_q     <= data_d;
            err_q      <= err_d;
            valid_q    <= valid_d;
            op_count_q <= op_count_d;
        end
    end

    // Next-state, operand capture, result capture and input handshake.
    always_comb begin
        state_d    = state_q;
        oc_d       = oc_q;
        a_d        = a_q;
        b_d        = b_q;
        data_d     = data_q;
        err_d      = err_q;
        valid_d    = valid_q;
        op_count_d = op_count_q;
        in_ready   = 1'b0;

        case (state_q)
            S_OC: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    oc_d    = in_data[2:0];
                    state_d = S_A;
                end
            end
            S_A: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d = in_data;
                    // NOT is unary: no B word follows, B is cleared instead.
                    if (oc_q == OC_NOT) begin
                        b_d     = '0;
                        state_d = S_EXEC;
                    end else begin
                        state_d = S_B;
                    end
                end
            end
            S_B: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    b_d     = in_data;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                // Operands have been stable at the ALU for a full cycle here.
                data_d  = select_result(oc_q, b_q, alu_f);
                err_d   = is_div_by_zero(oc_q, b_q);
                valid_d = 1'b1;
                state_d = S_OUT;
            end
            S_OUT: begin
                if (out_ready) begin
                    valid_d    = 1'b0;
                    op_count_d = op_count_q + 16'd1;
                    state_d    = S_OC;
                end
            end
            default: begin
                state_d = S_OC;
            end
        endcase
    end

    assign alu_oc    = oc_q;
    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign out_data  = data_q;
    assign out_err   = err_q;
    assign out_valid = valid_q;
    assign op_count  = op_count_q;

endmodule
